// File: rtl/gate_unit_pipe.sv
// rtl/gate_unit_pipe.sv - registered eight-function bitwise gate stage with skid buffer and transaction counter
module gate_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_op,
  output logic [CNT_W-1:0] txn_count
);

  function automatic logic [WIDTH-1:0] gate_fn(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y,
    input logic [2:0]       f
  );
    logic [WIDTH-1:0] r;
    case (f)
      3'd0:    r = ~x;
      3'd1:    r = x & y;
      3'd2:    r = x | y;
      3'd3:    r = x ^ y;
      3'd4:    r = ~(x & y);
      3'd5:    r = ~(x | y);
      3'd6:    r = ~(x ^ y);
      default: r = x;
    endcase
    return r;
  endfunction

  logic             skid_full;
  logic [WIDTH-1:0] skid_data;
  logic [2:0]       skid_op;
  logic [WIDTH-1:0] new_data;
  logic             accept;
  logic             out_fire;

  // in_ready is a pure register view so downstream stall cannot ripple upstream combinationally
  assign in_ready = ~skid_full;
  assign accept   = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign new_data = gate_fn(a, b, op);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_op    <= '0;
      skid_full <= 1'b0;
      skid_data <= '0;
      skid_op   <= '0;
      txn_count <= '0;
    end else begin
      if (out_fire)
        txn_count <= txn_count + 1'b1;

      if (skid_full) begin
        if (out_fire) begin
          out_data  <= skid_data;
          out_op    <= skid_op;
          out_valid <= 1'b1;
          skid_full <= 1'b0;
        end
      end else if (!out_valid || out_ready) begin
        if (accept) begin
          out_data  <= new_data;
          out_op    <= op;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (accept) begin
        skid_data <= new_data;
        skid_op   <= op;
        skid_full <= 1'b1;
      end
    end
  end

endmodule
